// File: rtl/fetch_if.sv
// Fetch-side bus bundle: instruction-memory request/ack, redirect strobe and
// the decode-facing valid/ready instruction head.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        PCSrc;
    logic [31:0] PCResult;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [31:0] PCPlus8;

    modport master (
        output imem_req, imem_addr, InstrValid, Instr, PCPlus8,
        input  imem_ack, imem_rdata, PCSrc, PCResult, InstrReady
    );
    modport slave (
        input  imem_req, imem_addr, InstrValid, Instr, PCPlus8,
        output imem_ack, imem_rdata, PCSrc, PCResult, InstrReady
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request feeding a 2-entry
// instruction buffer, with redirect squashing buffered and in-flight fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       count_q, count_d, count_after;
    logic [1:0][31:0] instr_q, pc_q;
    logic             req_q;
    logic             push, pop, launch, idx;
    logic [31:0]      launch_pc, target;
    logic             unused_pcres;

    assign unused_pcres = ^bus.PCResult[1:0];
    assign target       = {bus.PCResult[31:2], 2'b00};
    assign pop          = (count_q != 2'd0) && bus.InstrReady;
    assign count_after  = count_q - {1'b0, pop};
    assign idx          = count_after[0];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        launch     = 1'b0;
        launch_pc  = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (bus.PCSrc) begin
                    launch    = 1'b1;
                    launch_pc = target;
                end else if (count_after < 2'd2) begin
                    launch = 1'b1;
                end
            end
            WAIT: begin
                if (bus.imem_ack) begin
                    if (bus.PCSrc) begin
                        launch    = 1'b1;
                        launch_pc = target;
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                        // The push itself takes a slot; relaunch only if one is left.
                        if (count_after == 2'd0) launch = 1'b1;
                    end
                end else if (bus.PCSrc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    launch    = 1'b1;
                    launch_pc = bus.PCSrc ? target : fetch_pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.PCSrc) fetch_pc_d = target;
        if (launch) begin
            state_d    = WAIT;
            addr_d     = launch_pc;
            fetch_pc_d = launch_pc + 32'd4;
        end
        count_d = bus.PCSrc ? 2'd0 : count_after + {1'b0, push};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= 2'd0;
            instr_q    <= '0;
            pc_q       <= {RESET_PC, RESET_PC};
        end else begin
            state_q    <= state_d;
            req_q      <= (state_d != IDLE);
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            if (!bus.PCSrc && pop) begin
                instr_q[0] <= instr_q[1];
                pc_q[0]    <= pc_q[1];
            end
            // Later write wins over the shift when push lands in slot 0.
            if (push) begin
                instr_q[idx] <= bus.imem_rdata;
                pc_q[idx]    <= addr_q;
            end
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.InstrValid = (count_q != 2'd0);
    assign bus.Instr      = instr_q[0];
    assign bus.PCPlus8    = pc_q[0] + 32'd8;
endmodule
